// File: rtl/piton_rv_core.sv
// piton_rv_core: in-order RV32I-subset core (ADD/ADDI/LW/SW) on the L1.5 transducer port.
// Sleeps until a wake-up response arrives, then fetches 4-instruction bundles and runs them.
// Ports: clk; nrst (asynchronous, active-high reset); transducer_l15_* request bundle (out);
//   l15_transducer_* handshake and response bundle (in); transducer_l15_req_ack (out).
// Optional feature: define CORE_MUL_EN to decode RV32M MUL; otherwise MUL is a NOP.
module piton_rv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [31:0] transducer_l15_address,
  output logic [31:0] transducer_l15_data,
  output logic        transducer_l15_val,
  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_header_ack,
  input  logic        l15_transducer_val,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  input  logic [31:0] l15_transducer_returntype,
  output logic        transducer_l15_req_ack
);

  typedef enum logic [2:0] {
    S_SLEEP,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]  pc;
  logic [127:0] bundle;
  logic [1:0]   slot;
  logic [31:0]  regs [32];
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_st;
  logic [4:0]   mem_rd;
  logic         ack_q;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s;
  logic [31:0] rs1_val, rs2_val;
  logic        is_add, is_addi, is_lw, is_sw;
  logic        is_mul, is_mem;
  logic [31:0] mul_res, alu_res;
  logic        wb_alu;
  logic [31:0] ld_word;
  logic [3:0]  rt;
  logic        wake, fill, mem_done, last;
  logic        unused_ok;

  assign unused_ok = ^{l15_transducer_ack,
                       l15_transducer_returntype[31:4]};

  // Response classification; only the low nibble of returntype matters.
  assign rt       = l15_transducer_returntype[3:0];
  assign wake     = l15_transducer_val && (rt == 4'b0111);
  assign fill     = l15_transducer_val && (rt == 4'b0100);
  assign mem_done = l15_transducer_val &&
                    (mem_st ? (rt == 4'b0100) : (rt == 4'b0000));
  assign last     = (slot == 2'd3);

  // Bundle is kept as {data_0, data_1}, so slot 0 sits in the top word.
  always_comb begin
    instr = bundle[31:0];
    unique case (slot)
      2'd0:    instr = bundle[127:96];
      2'd1:    instr = bundle[95:64];
      2'd2:    instr = bundle[63:32];
      default: instr = bundle[31:0];
    endcase
  end

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign f3      = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign f7      = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  // x0 is never written, so it always reads back as zero.
  assign rs1_val = regs[rs1];
  assign rs2_val = regs[rs2];

  assign is_add  = (opcode == 7'b0110011) && (f3 == 3'b000) &&
                   (f7 == 7'b0000000);
  assign is_addi = (opcode == 7'b0010011) && (f3 == 3'b000);
  assign is_lw   = (opcode == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (f3 == 3'b010);
  assign is_mem  = is_lw || is_sw;

`ifdef CORE_MUL_EN
  assign is_mul  = (opcode == 7'b0110011) && (f3 == 3'b000) &&
                   (f7 == 7'b0000001);
  assign mul_res = rs1_val * rs2_val;
`else
  assign is_mul  = 1'b0;
  assign mul_res = '0;
`endif

  always_comb begin
    alu_res = rs1_val + rs2_val;
    unique case (1'b1)
      is_addi: alu_res = rs1_val + imm_i;
      is_mul:  alu_res = mul_res;
      default: ;
    endcase
  end

  assign wb_alu  = (state == S_EXEC) && (rd != 5'd0) &&
                   (is_add || is_addi || is_mul);
  assign ld_word = mem_addr[2] ? l15_transducer_data_0[31:0]
                               : l15_transducer_data_0[63:32];

  // State register
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= S_SLEEP;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_SLEEP:
        if (wake) state_nxt = S_FETCH_REQ;
      S_FETCH_REQ:
        if (l15_transducer_header_ack) state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT:
        if (fill) state_nxt = S_EXEC;
      S_EXEC:
        if (is_mem)    state_nxt = S_MEM_REQ;
        else if (last) state_nxt = S_FETCH_REQ;
      S_MEM_REQ:
        if (l15_transducer_header_ack) state_nxt = S_MEM_WAIT;
      S_MEM_WAIT:
        if (mem_done) state_nxt = last ? S_FETCH_REQ : S_EXEC;
      default:
        state_nxt = S_SLEEP;
    endcase
  end

  // Outputs; request fields come only from registered state so they hold steady.
  always_comb begin
    transducer_l15_val     = 1'b0;
    transducer_l15_rqtype  = 5'b00000;
    transducer_l15_size    = 3'b000;
    transducer_l15_address = '0;
    transducer_l15_data    = '0;
    unique case (state)
      S_FETCH_REQ: begin
        transducer_l15_val     = 1'b1;
        transducer_l15_rqtype  = 5'b10000;
        transducer_l15_size    = 3'b100;
        transducer_l15_address = {pc[31:4], 4'b0000};
      end
      S_MEM_REQ: begin
        transducer_l15_val     = 1'b1;
        transducer_l15_rqtype  = {4'b0000, mem_st};
        transducer_l15_size    = 3'b010;
        transducer_l15_address = mem_addr;
        transducer_l15_data    = mem_st ? mem_wdata : 32'd0;
      end
      default: ;
    endcase
  end

  assign transducer_l15_req_ack = ack_q;

  // Datapath: PC, bundle, slot, register file and pending memory op.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      pc        <= RESET_PC;
      bundle    <= '0;
      slot      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_st    <= 1'b0;
      mem_rd    <= '0;
      ack_q     <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        S_SLEEP:
          if (wake) ack_q <= 1'b1;
        S_FETCH_WAIT:
          if (fill) begin
            bundle <= {l15_transducer_data_0,
                       l15_transducer_data_1};
            slot   <= 2'd0;
            ack_q  <= 1'b1;
          end
        S_EXEC: begin
          if (wb_alu) regs[rd] <= alu_res;
          if (is_mem) begin
            mem_addr  <= rs1_val + (is_sw ? imm_s : imm_i);
            mem_wdata <= rs2_val;
            mem_st    <= is_sw;
            mem_rd    <= rd;
          end else if (last) begin
            pc <= pc + 32'd16;
          end else begin
            slot <= slot + 2'd1;
          end
        end
        S_MEM_WAIT:
          if (mem_done) begin
            ack_q <= 1'b1;
            if (!mem_st && (mem_rd != 5'd0))
              regs[mem_rd] <= ld_word;
            if (last) pc <= pc + 32'd16;
            else      slot <= slot + 2'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piton_rv_core.sv
// tb_piton_rv_core: randomized bundles checked against an instruction-level model
// of the core; the bench plays the L1.5 side (handshakes, fills, word memory).
module tb_piton_rv_core;

  logic        clk = 1'b0;
  logic        nrst;
  logic [4:0]  rqtype;
  logic [2:0]  size;
  logic [31:0] address;
  logic [31:0] data;
  logic        val;
  logic        l15_ack;
  logic        hdr;
  logic        l15_val;
  logic [63:0] d0, d1;
  logic [31:0] rtype;
  logic        req_ack;

  int n_checks = 0;
  int n_errors = 0;

  localparam int NB = 30;

  typedef struct {
    int         kind;
    logic [4:0] rd, rs1, rs2;
    logic [11:0] imm;
  } ins_t;

  logic [31:0] xr [32];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pc;

  piton_rv_core dut (
    .clk                       (clk),
    .nrst                      (nrst),
    .transducer_l15_rqtype     (rqtype),
    .transducer_l15_size       (size),
    .transducer_l15_address    (address),
    .transducer_l15_data       (data),
    .transducer_l15_val        (val),
    .l15_transducer_ack        (l15_ack),
    .l15_transducer_header_ack (hdr),
    .l15_transducer_val        (l15_val),
    .l15_transducer_data_0     (d0),
    .l15_transducer_data_1     (d1),
    .l15_transducer_returntype (rtype),
    .transducer_l15_req_ack    (req_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] r64();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    return {a, b};
  endfunction

  function automatic logic [31:0] sext(input logic [11:0] i);
    return {{20{i[11]}}, i};
  endfunction

  function automatic logic [31:0] enc(input ins_t n);
    logic [31:0] w;
    case (n.kind)
      0: w = {7'b0000000, n.rs2, n.rs1, 3'b000, n.rd, 7'b0110011};
      1: w = {n.imm, n.rs1, 3'b000, n.rd, 7'b0010011};
      2: w = {n.imm, n.rs1, 3'b010, n.rd, 7'b0000011};
      3: w = {n.imm[11:5], n.rs2, n.rs1, 3'b010,
              n.imm[4:0], 7'b0100011};
      5: w = {7'b0000001, n.rs2, n.rs1, 3'b000, n.rd, 7'b0110011};
      default: w = {n.imm, n.rs1, 3'b000, n.rd, 7'b0110111};
    endcase
    return w;
  endfunction

  function automatic ins_t mk(input int k, input int rd,
                              input int rs1, input int rs2,
                              input int imm);
    ins_t n;
    n.kind = k;
    n.rd   = 5'(rd);
    n.rs1  = 5'(rs1);
    n.rs2  = 5'(rs2);
    n.imm  = 12'(imm);
    return n;
  endfunction

  function automatic ins_t rnd_ins();
    int k, sel;
    int imm;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1: k = 0;
      2, 3: k = 1;
      4, 5: k = 2;
      6, 7: k = 3;
      8: k = 4;
      default: k = 5;
    endcase
    if ((k == 2 || k == 3) && $urandom_range(0, 1) == 1)
      imm = $urandom_range(0, 15) * 4;
    else
      imm = $urandom_range(0, 4095);
    return mk(k, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), imm);
  endfunction

  task automatic wr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) xr[rd] = v;
  endtask

  // One response beat; a consumed one must show a one-cycle req_ack.
  task automatic respond(input logic [3:0] rt,
                         input logic [63:0] a0,
                         input logic [63:0] a1,
                         input logic exp_ack);
    l15_val = 1'b1;
    rtype   = {28'h0, rt};
    d0      = a0;
    d1      = a1;
    tick;
    l15_val = 1'b0;
    rtype   = 32'hF;
    d0      = r64();
    d1      = r64();
    check("req_ack", {31'd0, req_ack}, {31'd0, exp_ack});
    if (exp_ack) begin
      tick;
      check("req_ack_pulse", {31'd0, req_ack}, 32'd0);
    end
  endtask

  task automatic expect_req(input string tag,
                            input logic [4:0] et,
                            input logic [2:0] es,
                            input logic [31:0] ea,
                            input logic [31:0] ed);
    int n;
    bit pre;
    n   = 0;
    pre = ($urandom_range(0, 3) == 0);
    if (pre) hdr = 1'b1;
    while (!val && n < 40) begin
      tick;
      n++;
    end
    if (!val) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      hdr = 1'b0;
      return;
    end
    check({tag, "_rqtype"}, {27'd0, rqtype}, {27'd0, et});
    check({tag, "_size"}, {29'd0, size}, {29'd0, es});
    check({tag, "_addr"}, address, ea);
    check({tag, "_data"}, data, ed);
    if (!pre) begin
      repeat ($urandom_range(0, 3)) begin
        tick;
        check({tag, "_hold_val"}, {31'd0, val}, 32'd1);
        check({tag, "_hold_addr"}, address, ea);
      end
      hdr = 1'b1;
    end
    tick;
    hdr = 1'b0;
    check({tag, "_done"}, {31'd0, val}, 32'd0);
  endtask

  task automatic run_ins(input ins_t n);
    logic [31:0] a, w, r;
    case (n.kind)
      0: wr(n.rd, xr[n.rs1] + xr[n.rs2]);
      1: wr(n.rd, xr[n.rs1] + sext(n.imm));
      2: begin
        a = xr[n.rs1] + sext(n.imm);
        expect_req("lw", 5'b00000, 3'b010, a, 32'd0);
        if (mem.exists(a)) w = mem[a];
        else begin
          w = $urandom;
          mem[a] = w;
        end
        if ($urandom_range(0, 1) == 1)
          respond(4'b0100, r64(), r64(), 1'b0);
        r = $urandom;
        respond(4'b0000, a[2] ? {r, w} : {w, r}, r64(), 1'b1);
        wr(n.rd, w);
      end
      3: begin
        a = xr[n.rs1] + sext(n.imm);
        expect_req("sw", 5'b00001, 3'b010, a, xr[n.rs2]);
        mem[a] = xr[n.rs2];
        if ($urandom_range(0, 1) == 1)
          respond(4'b0000, r64(), r64(), 1'b0);
        respond(4'b0100, r64(), r64(), 1'b1);
      end
      5: begin
`ifdef CORE_MUL_EN
        wr(n.rd, xr[n.rs1] * xr[n.rs2]);
`endif
      end
      default: ;
    endcase
  endtask

  initial begin
    ins_t b [4];
    int n;
    nrst    = 1'b0;
    l15_ack = 1'b0;
    hdr     = 1'b0;
    l15_val = 1'b0;
    d0      = '0;
    d1      = '0;
    rtype   = '0;
    #2 nrst = 1'b1;
    repeat (3) tick;
    check("rst_val", {31'd0, val}, 32'd0);
    check("rst_ack", {31'd0, req_ack}, 32'd0);
    check("rst_rqtype", {27'd0, rqtype}, 32'd0);
    check("rst_addr", address, 32'd0);
    nrst = 1'b0;
    repeat (10) tick;
    check("sleep_val", {31'd0, val}, 32'd0);
    respond(4'b0100, r64(), r64(), 1'b0);
    check("sleep_noise_val", {31'd0, val}, 32'd0);
    respond(4'b0111, r64(), r64(), 1'b1);

    for (int i = 0; i < 32; i++) xr[i] = '0;
    pc = 32'd0;
    for (int k = 0; k < NB; k++) begin
      expect_req("ifill", 5'b10000, 3'b100, pc, 32'd0);
      for (int i = 0; i < 32; i++)
        check($sformatf("x%0d", i), dut.regs[i], xr[i]);
      if (k == 0) begin
        b[0] = mk(1, 20, 0, 0, 5);
        b[1] = mk(0, 2, 20, 20, 0);
        b[2] = mk(3, 0, 0, 2, 0);
        b[3] = mk(2, 21, 0, 0, 0);
      end else if (k == 1) begin
        b[0] = mk(1, 0, 0, 0, 7);
        b[1] = mk(5, 3, 20, 2, 0);
        b[2] = mk(3, 0, 0, 3, 4);
        b[3] = mk(3, 0, 0, 0, 8);
      end else begin
        for (int s = 0; s < 4; s++) b[s] = rnd_ins();
      end
      if ($urandom_range(0, 1) == 1)
        respond($urandom_range(0, 1) == 1 ? 4'b0000 : 4'b0111,
                r64(), r64(), 1'b0);
      respond(4'b0100, {enc(b[0]), enc(b[1])},
              {enc(b[2]), enc(b[3])}, 1'b1);
      for (int s = 0; s < 4; s++) run_ins(b[s]);
      pc = pc + 32'd16;
    end

    n = 0;
    while (!val && n < 40) begin
      tick;
      n++;
    end
    check("last_fetch_val", {31'd0, val}, 32'd1);
    check("last_fetch_addr", address, pc);
    #2 nrst = 1'b1;
    #1;
    check("midrst_val", {31'd0, val}, 32'd0);
    check("midrst_ack", {31'd0, req_ack}, 32'd0);
    tick;
    nrst = 1'b0;
    repeat (5) tick;
    check("post_rst_val", {31'd0, val}, 32'd0);
    check("post_rst_x20", dut.regs[20], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
